// File: rtl/card_rng.sv
// rtl/card_rng.sv - bounded uniform random draw engine on a free-running Fibonacci LFSR
//
// Purpose: returns values in 0..RANGE-1 by rejection sampling the low OUT_W
// bits of a free-running LFSR. After MAX_TRY rejected samples it folds the
// last sample down by RANGE. Supports runtime reseeding and never lets the
// LFSR settle in the all-zero state.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   seed_load  in   load seed_in into the LFSR (aborts any draw)
//   seed_in    in   new seed, zero is replaced by SEED
//   req        in   draw request, ignored while busy
//   busy       out  draw in progress after a rejected sample
//   valid      out  one-cycle pulse, value holds a fresh draw
//   value      out  drawn value, held between pulses
//   forced     out  pulses with valid when value came from the fold path
module card_rng #(
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] TAPS    = 16'hD008,
  parameter logic [LFSR_W-1:0] SEED    = 16'h0002,
  parameter int                OUT_W   = 4,
  parameter int                RANGE   = 13,
  parameter int                MAX_TRY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  value,
  output logic              forced
);

  localparam int TRY_W = $clog2(MAX_TRY + 1);
  localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY);
  // One extra bit so RANGE == 2**OUT_W is representable.
  localparam logic [OUT_W:0]   RANGE_C  = (OUT_W + 1)'(RANGE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DRAW = 1'b1;

  logic [LFSR_W-1:0] r_lfsr;
  logic [0:0]        r_state;
  logic [TRY_W-1:0]  r_try;
  logic              r_busy;
  logic              r_valid;
  logic              r_forced;
  logic [OUT_W-1:0]  r_value;

  logic              w_fb;
  logic [LFSR_W-1:0] w_lfsr_shift;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic [LFSR_W-1:0] w_seed;
  logic [OUT_W-1:0]  w_sample;
  logic              w_accept;
  logic [OUT_W-1:0]  w_fold;
  logic [TRY_W-1:0]  w_try_inc;

  assign w_fb         = ^(r_lfsr & TAPS);
  assign w_lfsr_shift = {r_lfsr[LFSR_W-2:0], w_fb};
  // The all-zero state is a fixed point of the LFSR; reseed instead of entering it.
  assign w_lfsr_next  = (w_lfsr_shift == '0) ? SEED : w_lfsr_shift;
  assign w_seed       = (seed_in == '0) ? SEED : seed_in;

  assign w_sample  = r_lfsr[OUT_W-1:0];
  assign w_accept  = ({1'b0, w_sample} < RANGE_C);
  // A rejected sample lies in RANGE..2**OUT_W-1, so subtracting RANGE modulo
  // 2**OUT_W lands below RANGE because RANGE > 2**(OUT_W-1).
  assign w_fold    = w_sample - RANGE_C[OUT_W-1:0];
  assign w_try_inc = r_try + TRY_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr   <= SEED;
      r_state  <= S_IDLE;
      r_try    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_forced <= 1'b0;
      r_value  <= '0;
    end else begin
      r_lfsr   <= seed_load ? w_seed : w_lfsr_next;
      r_valid  <= 1'b0;
      r_forced <= 1'b0;
      if (seed_load) begin
        // Reseeding abandons any draw in flight and refuses a same-cycle req.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_try   <= '0;
      end else if (r_state == S_IDLE) begin
        if (req) begin
          if (w_accept) begin
            r_value <= w_sample;
            r_valid <= 1'b1;
          end else if (MAX_TRY == 1) begin
            r_value  <= w_fold;
            r_valid  <= 1'b1;
            r_forced <= 1'b1;
          end else begin
            r_state <= S_DRAW;
            r_busy  <= 1'b1;
            r_try   <= TRY_ONE;
          end
        end
      end else begin
        r_try <= w_try_inc;
        if (w_accept) begin
          r_value <= w_sample;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else if (w_try_inc == TRY_LAST) begin
          r_value  <= w_fold;
          r_valid  <= 1'b1;
          r_forced <= 1'b1;
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
        end
      end
    end
  end

  assign busy   = r_busy;
  assign valid  = r_valid;
  assign value  = r_value;
  assign forced = r_forced;

endmodule
